bp_stream_pc_bridge: RTL

PC-side endpoint of the host stream link. An AXI-Lite slave, driven by the PC host (PCIe/PS bridge), sends each write to the host stream as one (addr, data) word pair: address 0x10 carries NBF words, 0x20 carries MMIO responses. A small FIFO collects the outbound stream words from BP (the address then data beat pairs of BP MMIO requests); AXI-Lite reads pop that FIFO or return status. The block sits between the PC interconnect and the BP stream host.

---
 rtl/bp_stream_pc_bridge_if.sv | 55 +++++
 rtl/bp_stream_pc_bridge.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bp_stream_pc_bridge_if.sv
// AXI-Lite slave channel bundle between the PC interconnect (master) and the stream bridge (slave).
interface bp_stream_pc_bridge_if #(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32
);
    logic [addr_width_p-1:0]   s_axil_awaddr_i;
    logic [2:0]                s_axil_awprot_i;
    logic                      s_axil_awvalid_i;
    logic                      s_axil_awready_o;

    logic [data_width_p-1:0]   s_axil_wdata_i;
    logic [data_width_p/8-1:0] s_axil_wstrb_i;
    logic                      s_axil_wvalid_i;
    logic                      s_axil_wready_o;

    logic [1:0]                s_axil_bresp_o;
    logic                      s_axil_bvalid_o;
    logic                      s_axil_bready_i;

    logic [addr_width_p-1:0]   s_axil_araddr_i;
    logic [2:0]                s_axil_arprot_i;
    logic                      s_axil_arvalid_i;
    logic                      s_axil_arready_o;

    logic [data_width_p-1:0]   s_axil_rdata_o;
    logic [1:0]                s_axil_rresp_o;
    logic                      s_axil_rvalid_o;
    logic                      s_axil_rready_i;

    modport master (
        output s_axil_awaddr_i, s_axil_awprot_i, s_axil_awvalid_i,
        input  s_axil_awready_o,
        output s_axil_wdata_i, s_axil_wstrb_i, s_axil_wvalid_i,
        input  s_axil_wready_o,
        input  s_axil_bresp_o, s_axil_bvalid_o,
        output s_axil_bready_i,
        output s_axil_araddr_i, s_axil_arprot_i, s_axil_arvalid_i,
        input  s_axil_arready_o,
        input  s_axil_rdata_o, s_axil_rresp_o, s_axil_rvalid_o,
        output s_axil_rready_i
    );

    modport slave (
        input  s_axil_awaddr_i, s_axil_awprot_i, s_axil_awvalid_i,
        output s_axil_awready_o,
        input  s_axil_wdata_i, s_axil_wstrb_i, s_axil_wvalid_i,
        output s_axil_wready_o,
        output s_axil_bresp_o, s_axil_bvalid_o,
        input  s_axil_bready_i,
        input  s_axil_araddr_i, s_axil_arprot_i, s_axil_arvalid_i,
        output s_axil_arready_o,
        output s_axil_rdata_o, s_axil_rresp_o, s_axil_rvalid_o,
        input  s_axil_rready_i
    );
endinterface

// File: rtl/bp_stream_pc_bridge.sv
// AXI-Lite writes become one stream (addr,data) word toward BP; reads pop a BP->PC FIFO or return status.
// Stream word 1 cycle after last of AW/W, B 1 cycle after yumi, R 1 cycle after AR; stream_ready_o low when FIFO full.
module bp_stream_pc_bridge #(
    parameter int stream_addr_width_p = 32,
    parameter int stream_data_width_p = 32,
    parameter int fifo_els_p          = 8,
    localparam int cnt_width_lp       = $clog2(fifo_els_p + 1)
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    bp_stream_pc_bridge_if.slave           s_axil,
    output logic                           stream_v_o,
    output logic [stream_addr_width_p-1:0] stream_addr_o,
    output logic [stream_data_width_p-1:0] stream_data_o,
    input  logic                           stream_yumi_i,
    input  logic                           stream_v_i,
    input  logic [stream_data_width_p-1:0] stream_data_i,
    output logic                           stream_ready_o
);
    localparam int ptr_width_lp = $clog2(fifo_els_p);
    localparam logic [stream_addr_width_p-1:0] fifo_addr_lp   = stream_addr_width_p'('h00);
    localparam logic [stream_addr_width_p-1:0] count_addr_lp  = stream_addr_width_p'('h04);
    localparam logic [stream_addr_width_p-1:0] status_addr_lp = stream_addr_width_p'('h08);

    typedef enum logic [1:0] {e_w_idle, e_w_stream, e_w_resp} w_state_e;
    typedef enum logic       {e_r_idle, e_r_resp} r_state_e;

    w_state_e                       w_state_q, w_state_d;
    r_state_e                       r_state_q, r_state_d;
    logic                           aw_held_q, aw_held_d;
    logic                           w_held_q, w_held_d;
    logic [stream_addr_width_p-1:0] addr_q, addr_d;
    logic [stream_data_width_p-1:0] data_q, data_d;
    logic [stream_data_width_p-1:0] rdata_q, rdata_d;
    logic [1:0]                     rresp_q, rresp_d;
    logic [ptr_width_lp-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [cnt_width_lp-1:0]        count_q, count_d;
    logic [stream_data_width_p-1:0] mem_q [fifo_els_p];

    logic aw_fire, w_fire, ar_fire, push, pop, fifo_empty;
    logic unused_sideband;

    assign unused_sideband = ^{s_axil.s_axil_awprot_i, s_axil.s_axil_arprot_i, s_axil.s_axil_wstrb_i};

    // Readies depend only on state flops, never on the incoming valids.
    assign s_axil.s_axil_awready_o = (w_state_q == e_w_idle) && !aw_held_q;
    assign s_axil.s_axil_wready_o  = (w_state_q == e_w_idle) && !w_held_q;
    assign s_axil.s_axil_bvalid_o  = (w_state_q == e_w_resp);
    assign s_axil.s_axil_bresp_o   = 2'b00;
    assign s_axil.s_axil_arready_o = (r_state_q == e_r_idle);
    assign s_axil.s_axil_rvalid_o  = (r_state_q == e_r_resp);
    assign s_axil.s_axil_rdata_o   = rdata_q;
    assign s_axil.s_axil_rresp_o   = rresp_q;

    assign stream_v_o     = (w_state_q == e_w_stream);
    assign stream_addr_o  = addr_q;
    assign stream_data_o  = data_q;
    assign stream_ready_o = (count_q != cnt_width_lp'(fifo_els_p));

    assign aw_fire    = s_axil.s_axil_awvalid_i && s_axil.s_axil_awready_o;
    assign w_fire     = s_axil.s_axil_wvalid_i && s_axil.s_axil_wready_o;
    assign ar_fire    = s_axil.s_axil_arvalid_i && s_axil.s_axil_arready_o;
    assign push       = stream_v_i && stream_ready_o;
    assign fifo_empty = (count_q == '0);

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        addr_d    = addr_q;
        data_d    = data_q;
        unique case (w_state_q)
            e_w_idle: begin
                if (aw_fire) begin
                    aw_held_d = 1'b1;
                    addr_d    = s_axil.s_axil_awaddr_i;
                end
                if (w_fire) begin
                    w_held_d = 1'b1;
                    data_d   = s_axil.s_axil_wdata_i;
                end
                if (aw_held_d && w_held_d) w_state_d = e_w_stream;
            end
            e_w_stream: begin
                if (stream_yumi_i) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = e_w_resp;
                end
            end
            e_w_resp: begin
                if (s_axil.s_axil_bready_i) w_state_d = e_w_idle;
            end
            default: w_state_d = e_w_idle;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        pop       = 1'b0;
        unique case (r_state_q)
            e_r_idle: begin
                if (ar_fire) begin
                    r_state_d = e_r_resp;
                    rdata_d   = '0;
                    rresp_d   = 2'b00;
                    if (s_axil.s_axil_araddr_i == fifo_addr_lp) begin
                        pop = !fifo_empty;
                        if (!fifo_empty) rdata_d = mem_q[rd_ptr_q];
                    end else if (s_axil.s_axil_araddr_i == count_addr_lp) begin
                        rdata_d = stream_data_width_p'(count_q);
                    end else if (s_axil.s_axil_araddr_i == status_addr_lp) begin
                        rdata_d[0] = (w_state_q != e_w_idle);
                    end else begin
                        rresp_d = 2'b10;
                    end
                end
            end
            e_r_resp: begin
                if (s_axil.s_axil_rready_i) r_state_d = e_r_idle;
            end
            default: r_state_d = e_r_idle;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + ptr_width_lp'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + ptr_width_lp'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + cnt_width_lp'(1);
        else if (!push && pop) count_d = count_q - cnt_width_lp'(1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            w_state_q <= e_w_idle;
            r_state_q <= e_r_idle;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone defines which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= stream_data_i;
    end
endmodule
